// File: rtl/encoder_speed_sampler.sv
// rtl/encoder_speed_sampler.sv - windowed speed sampler for a quadrature decoder count (optional ENC_POS_ACCUM_EN)
module encoder_speed_sampler #(
    parameter int WINDOW_CYCLES = 100000,
    parameter int STALL_WINDOWS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] cnter,
    input  logic        dir,
    input  logic        up_of,
    input  logic        down_of,
    output logic        enc_clr,
    output logic [15:0] speed,
    output logic        speed_dir,
    output logic        speed_sat,
    output logic        speed_valid,
    input  logic        speed_ready,
    output logic        overrun,
    output logic        stall,
    output logic [31:0] pos
);

    localparam logic [23:0] TIMER_LAST = 24'(WINDOW_CYCLES - 1);
    localparam logic [7:0]  STALL_MAX  = 8'(STALL_WINDOWS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [23:0] timer;
    logic [7:0]  zero_cnt;
    logic        win_sat;
    logic        en_q;
    logic        capture;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, decoder clear and capture strobe; a window only captures while still enabled
    always_comb begin
        state_next = state;
        enc_clr    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN: begin
                enc_clr = (timer != TIMER_LAST) && !rst;
                capture = en && (timer == TIMER_LAST);
                if (!en) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Window timer and saturation flag accumulated across the window
    always_ff @(posedge clk) begin
        if (rst || state != RUN || !en) begin
            timer   <= '0;
            win_sat <= 1'b0;
        end else if (timer == TIMER_LAST) begin
            timer   <= '0;
            win_sat <= 1'b0;
        end else begin
            timer   <= timer + 24'd1;
            win_sat <= win_sat | up_of | down_of;
        end
    end

    // Sample register, handshake and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            speed       <= '0;
            speed_dir   <= 1'b0;
            speed_sat   <= 1'b0;
            speed_valid <= 1'b0;
            overrun     <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            en_q <= en;
            if (capture) begin
                speed       <= cnter;
                speed_dir   <= dir;
                speed_sat   <= win_sat | up_of | down_of;
                speed_valid <= 1'b1;
            end else if (speed_valid && speed_ready) begin
                speed_valid <= 1'b0;
            end
            if (en_q && !en)
                overrun <= 1'b0;
            else if (capture && speed_valid && !speed_ready)
                overrun <= 1'b1;
        end
    end

    // Consecutive zero-speed window counter; cleared when sampling stops
    always_ff @(posedge clk) begin
        if (rst || (state == RUN && !en)) begin
            zero_cnt <= '0;
        end else if (capture) begin
            if (cnter != 16'd0)
                zero_cnt <= '0;
            else if (zero_cnt != STALL_MAX)
                zero_cnt <= zero_cnt + 8'd1;
        end
    end

    assign stall = (zero_cnt == STALL_MAX);

`ifdef ENC_POS_ACCUM_EN
    // Position accumulator, wraps modulo 2^32 and holds through IDLE
    always_ff @(posedge clk) begin
        if (rst)          pos <= '0;
        else if (capture) pos <= pos + {{16{cnter[15]}}, cnter};
    end
`else
    assign pos = 32'd0;
`endif

endmodule

// File: tb/tb_encoder_speed_sampler.sv
// tb/tb_encoder_speed_sampler.sv - directed self-checking bench for encoder_speed_sampler
`timescale 1ns/1ps
module tb_encoder_speed_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] cnter;
    logic        dir;
    logic        up_of;
    logic        down_of;
    logic        enc_clr;
    logic [15:0] speed;
    logic        speed_dir;
    logic        speed_sat;
    logic        speed_valid;
    logic        speed_ready;
    logic        overrun;
    logic        stall;
    logic [31:0] pos;

    int compared   = 0;
    int mismatched = 0;
    int n;
    int clr_seen;

    encoder_speed_sampler #(.WINDOW_CYCLES(100), .STALL_WINDOWS(3)) dut (
        .clk(clk), .rst(rst), .en(en), .cnter(cnter), .dir(dir),
        .up_of(up_of), .down_of(down_of), .enc_clr(enc_clr), .speed(speed),
        .speed_dir(speed_dir), .speed_sat(speed_sat), .speed_valid(speed_valid),
        .speed_ready(speed_ready), .overrun(overrun), .stall(stall), .pos(pos)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance until the capture cycle (enc_clr low), bounded
    task automatic wait_capture(input string tag, input int exp_n);
        int k;
        k = 0;
        while (enc_clr !== 1'b0 && k < 300) begin
            tick();
            k++;
        end
        check(tag, 32'(k), 32'(exp_n));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnter = 16'h0025; dir = 1'b0;
        up_of = 1'b0; down_of = 1'b0; speed_ready = 1'b1;
        tick(); tick();
        check("rst_enc_clr", 32'(enc_clr), 32'd0);
        check("rst_speed", 32'(speed), 32'd0);
        check("rst_valid", 32'(speed_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_pos", pos, 32'd0);

        // first window
        rst = 1'b0; en = 1'b1;
        tick();
        check("run_enc_clr", 32'(enc_clr), 32'd1);
        wait_capture("w1_len", 99);
        check("w1_no_early_valid", 32'(speed_valid), 32'd0);
        tick();
        check("w1_speed", 32'(speed), 32'h0025);
        check("w1_valid", 32'(speed_valid), 32'd1);
        check("w1_sat", 32'(speed_sat), 32'd0);
        check("w1_enc_clr_back", 32'(enc_clr), 32'd1);
        tick();
        check("w1_valid_pulse", 32'(speed_valid), 32'd0);

        // overrun: two captures without ready
        cnter = 16'hFFF6; dir = 1'b1; speed_ready = 1'b0;
        wait_capture("w2_len", 98);
        tick();
        check("w2_valid", 32'(speed_valid), 32'd1);
        check("w2_no_overrun", 32'(overrun), 32'd0);
        wait_capture("w3_len", 99);
        tick();
        check("w3_overrun", 32'(overrun), 32'd1);
        check("w3_valid", 32'(speed_valid), 32'd1);
        check("w3_speed", 32'(speed), 32'h0000FFF6);
        check("w3_dir", 32'(speed_dir), 32'd1);
        speed_ready = 1'b1;
        tick();
        check("w3_accept", 32'(speed_valid), 32'd0);
        check("w3_overrun_sticky", 32'(overrun), 32'd1);

        // saturation flag from a single up_of pulse at timer 40
        cnter = 16'h0025; dir = 1'b0;
        repeat (39) tick();
        up_of = 1'b1;
        tick();
        up_of = 1'b0;
        wait_capture("w4_len", 58);
        tick();
        check("w4_sat", 32'(speed_sat), 32'd1);
        wait_capture("w5_len", 99);
        tick();
        check("w5_sat_clean", 32'(speed_sat), 32'd0);

        // stall after three zero windows
        cnter = 16'h0000;
        for (int k = 1; k <= 3; k++) begin
            wait_capture("stall_len", 99);
            tick();
            check("stall_level", 32'(stall), (k == 3) ? 32'd1 : 32'd0);
        end
        cnter = 16'h0004;
        wait_capture("unstall_len", 99);
        tick();
        check("unstall", 32'(stall), 32'd0);
        check("unstall_speed", 32'(speed), 32'h0004);

        // en dropped mid-window with a sample pending
        speed_ready = 1'b0; cnter = 16'h0033;
        wait_capture("w6_len", 99);
        tick();
        check("w6_valid", 32'(speed_valid), 32'd1);
        repeat (50) tick();
        en = 1'b0;
        tick();
        check("idle_enc_clr", 32'(enc_clr), 32'd0);
        check("idle_valid_kept", 32'(speed_valid), 32'd1);
        check("idle_speed_kept", 32'(speed), 32'h0033);
        check("idle_overrun_clr", 32'(overrun), 32'd0);
        cnter = 16'h0044;
        clr_seen = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (enc_clr !== 1'b0) clr_seen++;
        end
        check("idle_clr_low", 32'(clr_seen), 32'd0);
        check("idle_no_capture", 32'(speed), 32'h0033);

        // re-enable; capture coincides with acceptance
        en = 1'b1; cnter = 16'h0055;
        tick();
        wait_capture("w7_len", 99);
        speed_ready = 1'b1;
        tick();
        check("w7_speed", 32'(speed), 32'h0055);
        check("w7_valid", 32'(speed_valid), 32'd1);
        check("w7_no_overrun", 32'(overrun), 32'd0);
        tick();
        check("w7_drain", 32'(speed_valid), 32'd0);

        // reset mid-window, then position accumulation
        rst = 1'b1;
        tick();
        check("rst2_enc_clr", 32'(enc_clr), 32'd0);
        check("rst2_speed", 32'(speed), 32'd0);
        check("rst2_pos", pos, 32'd0);
        rst = 1'b0; cnter = 16'h7FFF;
        tick();
        wait_capture("p1_len", 99);
        tick();
`ifdef ENC_POS_ACCUM_EN
        check("pos1", pos, 32'h00007FFF);
`else
        check("pos1", pos, 32'd0);
`endif
        cnter = 16'h8001;
        wait_capture("p2_len", 99);
        tick();
        check("pos2", pos, 32'h00000000);
        cnter = 16'h0010;
        wait_capture("p3_len", 99);
        tick();
`ifdef ENC_POS_ACCUM_EN
        check("pos3", pos, 32'h00000010);
`else
        check("pos3", pos, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
